mips_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU over WIDTH cycles and owns the architectural HI/LO registers.
- Provides single-cycle MTHI/MTLO writes, a start/busy/done handshake to the pipeline controller, and a cancel input for pipeline flushes.

---
 rtl/mips_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO registers.
// It does one shift-add or restoring shift-subtract step per cycle, then applies the sign fix-up in a single final cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 div_q, div_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbzp_q, dbzp_d;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic s);
        return s ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic s);
        return s ? ((~v) + (2*WIDTH)'(1)) : v;
    endfunction

    logic signed [WIDTH-1:0] a_sgn, b_sgn;
    logic                    op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]        a_abs, b_abs;

    assign a_sgn     = a;
    assign b_sgn     = b;
    assign op_signed = ~op[0];
    assign a_neg     = op_signed & (a_sgn < 0);
    assign b_neg     = op_signed & (b_sgn < 0);
    assign a_abs     = neg_if(a, a_neg);
    assign b_abs     = neg_if(b, b_neg);

    // Multiply step: the low half holds the remaining multiplier bits, the product grows in from the top.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: the partial remainder sits in the top half, and quotient bits shift in from the bottom.
    logic [WIDTH:0]       rem_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_acc;
    assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge  = rem_sh >= {1'b0, opnd_q};
    assign div_rem = div_ge ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
    assign div_acc = {div_rem, acc_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbzp_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b100: hi_d = a;
                        3'b101: lo_d = a;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            div_d   = op[1];
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            dbz_d   = (b == '0);
                            opnd_d  = op[1] ? b_abs : a_abs;
                            acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                            cnt_d   = CNT_W'(WIDTH - 1);
                            state_d = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_q ? div_acc : mul_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    // A zero divisor leaves the dividend as the remainder, so the sign fix-up restores the original a.
                    if (div_q) begin
                        lo_d = dbz_q ? '1 : neg_if(acc_q[WIDTH-1:0], qneg_q);
                        hi_d = neg_if(acc_q[2*WIDTH-1:WIDTH], rneg_q);
                    end else begin
                        {hi_d, lo_d} = neg2_if(acc_q, qneg_q);
                    end
                    done_d = 1'b1;
                    dbzp_d = div_q & dbz_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbzp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbzp_q  <= dbzp_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbzp_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: an arithmetic reference model checked every cycle, plus literal expectations.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cancel = 1'b0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural result: {div_by_zero, hi, lo}.
    function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, ux, uy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            3'd0: begin p = 64'(sx * sy); return {1'b0, p}; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
            default: begin
                if (y == '0) return {1'b1, x, 32'hFFFF_FFFF};
                if (o == 3'd2) begin q = sx / sy; r = sx % sy; end
                else begin q = ux / uy; r = ux % uy; end
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    int            m_left = 0;
    logic [64:0]   m_pend = '0;
    logic [W-1:0]  m_hi = '0, m_lo = '0;
    logic          m_done = 1'b0, m_dbz = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_left > 0) begin
                if (cancel) m_left <= 0;
                else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_dbz  <= m_pend[64];
                        m_hi   <= m_pend[63:32];
                        m_lo   <= m_pend[31:0];
                        m_done <= 1'b1;
                    end
                end
            end else if (start) begin
                if (op == 3'd4) m_hi <= a;
                else if (op == 3'd5) m_lo <= a;
                else if (op <= 3'd3) begin
                    m_pend <= ref_result(op, a, b);
                    m_left <= W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("done", 64'(done), 64'(m_done));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    int bc;

    initial begin
        #1 reset = 1'b1;
        #1 mon_en = 1'b1;
        idle(3);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        #2 reset = 1'b0;

        chk("model_mult", 64'(ref_result(3'd0, 32'hFFFF_FFFD, 32'd5)), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model_divu", 64'(ref_result(3'd3, 32'd100, 32'd7)), {32'd2, 32'd14});
        chk("model_dbz", 64'(ref_result(3'd3, 32'd9, 32'd0) >> 64), 64'd1);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, bc);
        chk("t1_busy_cycles", 64'(bc), 64'd33);
        chk("t1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t1_lo", 64'(lo), 64'hFFFF_FFF1);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
        chk("t2_multu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd3, 32'd100, 32'd7, bc);
        chk("t2_divu", {hi, lo}, {32'd2, 32'd14});

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc);
        chk("t3_div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc);
        chk("t3_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        chk("t3_ovf_dbz", 64'(div_by_zero), 64'd0);

        run_op(3'd3, 32'd9, 32'd0, bc);
        chk("t4_dbz_res", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
        chk("t4_dbz_flag", 64'(div_by_zero), 64'd1);
        @(negedge clk);
        chk("t4_dbz_pulse", 64'(div_by_zero), 64'd0);

        @(negedge clk); start = 1'b1; op = 3'd4; a = 32'h1234;
        @(negedge clk); start = 1'b0;
        chk("t5_mthi", 64'(hi), 64'h1234);
        start = 1'b1; op = 3'd5; a = 32'h5678;
        @(negedge clk); start = 1'b0;
        chk("t5_mtlo", 64'(lo), 64'h5678);
        chk("t5_busy", 64'(busy), 64'd0);

        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk); start = 1'b0;
        idle(8);
        start = 1'b1; a = 32'd5; b = 32'd5;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        chk("t5_ignored_start", {hi, lo}, 64'd6);

        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7;
        @(negedge clk); start = 1'b0;
        idle(10);
        cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        chk("t6_cancel_busy", 64'(busy), 64'd0);
        idle(40);
        chk("t6_cancel_hold", {hi, lo}, 64'd6);

        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7;
        @(negedge clk); start = 1'b0;
        idle(18);
        #2 reset = 1'b1;
        #1;
        chk("t6_reset_hilo", {hi, lo}, 64'd0);
        chk("t6_reset_busy", 64'(busy), 64'd0);
        idle(2);
        #2 reset = 1'b0;
        idle(40);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) != 0);
            op     = 3'($urandom_range(0, 7));
            a      = pick();
            b      = pick();
            cancel = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
